vc_dot_accum: RTL

VC_DOT_ACCUM -- requirements
Module: vc_dot_accum

---
 rtl/vc_dot_accum.sv | 91 +++++++++
 1 files changed

// File: rtl/vc_dot_accum.sv
// Streaming dot-product accumulator: sums VEC_LEN unsigned product terms into a
// registered result, with a sticky flag for any carry out of the accumulator.
module vc_dot_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int VEC_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  output logic                  dbg_state
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both 1; valid never depends on ready, and ready never depends on valid.

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 last_term;
  logic [ACC_WIDTH:0]   sum;

  assign accept    = in_val && (state_q == ACCUM);
  assign last_term = (cnt_q == LAST);
  assign sum       = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_term) state_d = DONE;
      DONE:    if (out_rdy) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath next-state; the drain cycle clears everything so no term is taken.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      acc_d = sum[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sum[ACC_WIDTH];
      cnt_d = last_term ? '0 : cnt_q + CW'(1);
    end else if (state_q == DONE && out_rdy) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    in_rdy    = (state_q == ACCUM);
    out_val   = (state_q == DONE);
    out_data  = acc_q;
    out_ovf   = ovf_q;
    dbg_state = state_q;
  end

endmodule
